// File: rtl/sccpu_store_buffer.sv
// Store buffer between the single-cycle CPU and a slow req/ack data memory.
// Stores retire in one cycle into a FIFO; loads forward from it or wait for a drained read.
module sccpu_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_wmem,
    input  logic          cpu_rmem,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

    logic [AW-1:0] buf_addr_q [DEPTH];
    logic [DW-1:0] buf_data_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [CW-1:0] count_q, count_d, count_after;
    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          is_store, is_load, full, push, pop;
    logic          fwd_hit, load_hit, miss_pending;
    logic [DW-1:0] fwd_data;

    // Entry gi is the gi-th oldest valid store; higher gi is younger.
    logic [PW-1:0]    age_idx [DEPTH];
    logic [DEPTH-1:0] age_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi] = head_q + PW'(gi);
            assign age_hit[gi] = (CW'(gi) < count_q) &&
                                 (buf_addr_q[age_idx[gi]][AW-1:2] == cpu_addr[AW-1:2]);
        end
    endgenerate

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_hit[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[age_idx[i]];
            end
        end
    end

    // A simultaneous store and load strobe is treated as a store only.
    assign is_store     = cpu_wmem;
    assign is_load      = cpu_rmem & ~cpu_wmem;
    assign full         = (count_q == CW'(DEPTH));
    assign push         = is_store & ~full;
    assign pop          = (state_q == WRITE) & mem_ack;
    assign load_hit     = is_load & fwd_hit;
    assign miss_pending = is_load & ~fwd_hit & (state_q != RDONE);
    assign count_after  = count_q + CW'(push) - CW'(pop);
    assign head_nxt     = head_q + PW'(1);

    assign cpu_stall = (is_store & full) | miss_pending;
    assign cpu_rdata = load_hit ? fwd_data : rdata_q;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q + PW'(pop);
        tail_d      = tail_q + PW'(push);
        count_d     = count_after;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = load_hit ? fwd_data : rdata_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = buf_addr_q[head_q];
                    mem_wdata_d = buf_data_q[head_q];
                end else if (miss_pending) begin
                    state_d    = READ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = cpu_addr;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    if (count_after != '0) begin
                        // With one entry left, the next head is the store landing this edge.
                        if (count_q == CW'(1)) begin
                            mem_addr_d  = cpu_addr;
                            mem_wdata_d = cpu_wdata;
                        end else begin
                            mem_addr_d  = buf_addr_q[head_nxt];
                            mem_wdata_d = buf_data_q[head_nxt];
                        end
                    end else if (miss_pending) begin
                        state_d    = READ;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cpu_addr;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            READ: begin
                if (mem_ack) begin
                    state_d   = RDONE;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_rdata;
                end
            end
            RDONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_addr_q[tail_q] <= cpu_addr;
            buf_data_q[tail_q] <= cpu_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sccpu_store_buffer.sv
// Randomized bench for sccpu_store_buffer: a queue-and-memory reference model predicts
// stalls, forwarded data, memory write order and read results.
module tb_sccpu_store_buffer;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_wmem = 1'b0, cpu_rmem = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    sccpu_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .cpu_wmem(cpu_wmem), .cpu_rmem(cpu_rmem),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_model [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          req_age = 0;
    bit          ack_en = 1'b1, force_ack = 1'b0, rnd_ack = 1'b0;
    int          ack_lat = 2;
    bit          prev_wr_ack = 1'b0, rd_acked = 1'b0;
    logic [31:0] rd_val = '0, last_rdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] ad);
        return mem_model.exists(ad) ? mem_model[ad] : 32'h0;
    endfunction

    // One CPU cycle, entered and left at posedge+1.
    task automatic cycle(input bit wm, input bit rm, input logic [31:0] a,
                         input logic [31:0] d, output bit done);
        bit          is_store, is_load, full, hit, miss, ack, rd_ack_now;
        logic [31:0] hd;
        ent_t        e;
        cpu_wmem  = wm;
        cpu_rmem  = rm;
        cpu_addr  = a;
        cpu_wdata = d;
        is_store  = wm;
        is_load   = rm && !wm;
        full      = (q.size() == DEPTH);
        hit       = 1'b0;
        hd        = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].a[31:2] == a[31:2]) begin
                hit = 1'b1;
                hd  = q[i].d;
            end
        end
        miss = is_load && !hit && !rd_acked;
        ack  = mem_req && (force_ack || (ack_en &&
               (rnd_ack ? ($urandom_range(0, 2) == 0) : (req_age >= ack_lat))));
        mem_ack   = ack;
        mem_rdata = (ack && !mem_we) ? mem_rd(mem_addr) : $urandom();
        #3;
        if (is_store) begin
            check("store_stall", cpu_stall, full);
        end else if (is_load) begin
            if (hit) begin
                check("fwd_stall", cpu_stall, 0);
                check("fwd_data", cpu_rdata, hd);
                last_rdata = hd;
            end else if (rd_acked) begin
                check("rdone_stall", cpu_stall, 0);
                check("miss_data", cpu_rdata, rd_val);
                last_rdata = rd_val;
            end else begin
                check("miss_stall", cpu_stall, 1);
            end
        end else begin
            check("idle_stall", cpu_stall, 0);
        end
        if (!(is_load && (hit || rd_acked))) check("rdata_hold", cpu_rdata, last_rdata);
        if (mem_req && mem_we) begin
            if (q.size() == 0) check("spurious_wr", mem_req, 0);
            else begin
                check("wr_addr", mem_addr, q[0].a);
                check("wr_data", mem_wdata, q[0].d);
            end
        end else if (mem_req) begin
            if (!miss || q.size() != 0) check("spurious_rd", mem_req, 0);
            else check("rd_addr", mem_addr, a);
        end else if (prev_wr_ack && q.size() != 0) begin
            check("b2b_req", mem_req, 1);
        end
        rd_ack_now = ack && !mem_we;
        if (ack && mem_we && q.size() != 0) begin
            $display("mem write addr=%h data=%h", q[0].a, q[0].d);
            mem_model[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (rd_ack_now) begin
            rd_val = mem_rd(a);
            $display("mem read  addr=%h data=%h", a, rd_val);
        end
        if (is_store && !full) begin
            e.a = a;
            e.d = d;
            q.push_back(e);
        end
        done        = is_store ? !full : (is_load ? (hit || rd_acked) : 1'b1);
        prev_wr_ack = ack && mem_we;
        req_age     = ack ? 0 : (mem_req ? req_age + 1 : 0);
        rd_acked    = rd_ack_now;
        @(posedge clock);
        #1;
    endtask

    task automatic op(input bit wm, input bit rm, input logic [31:0] a, input logic [31:0] d);
        bit done;
        int n;
        n = 0;
        do begin
            cycle(wm, rm, a, d, done);
            n++;
        end while (!done && n < 300);
        if (!done) check("op_timeout", done, 1);
    endtask

    task automatic idle(input int n);
        bit done;
        repeat (n) cycle(0, 0, 32'h0, 32'h0, done);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            idle(1);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          done;
        int          r;
        logic [31:0] ra;
        #2;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_stall", cpu_stall, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        idle(2);

        // In-order, back-to-back drain with fixed memory latency
        ack_en = 1; rnd_ack = 0; ack_lat = 2;
        op(1, 0, 32'h10, 32'hA);
        op(1, 0, 32'h14, 32'hB);
        op(1, 0, 32'h18, 32'hC);
        drain();

        // Full buffer, single ack pulse
        ack_en = 0;
        for (int k = 0; k < 4; k++) op(1, 0, 32'h100 + 32'(k * 4), 32'h200 + 32'(k));
        cycle(1, 0, 32'h110, 32'h204, done);
        force_ack = 1;
        cycle(1, 0, 32'h110, 32'h204, done);
        force_ack = 0;
        cycle(1, 0, 32'h110, 32'h204, done);
        cycle(1, 0, 32'h114, 32'h205, done);
        ack_en = 1;
        drain();

        // Youngest-match forwarding
        ack_en = 0;
        op(1, 0, 32'h20, 32'h1);
        op(1, 0, 32'h20, 32'h2);
        op(0, 1, 32'h20, 32'h0);
        ack_en = 1;
        drain();

        // Load miss waits behind buffered stores
        mem_model[32'h40] = 32'h55;
        ack_en = 0;
        op(1, 0, 32'h30, 32'h3);
        op(1, 0, 32'h34, 32'h4);
        ack_en = 1; ack_lat = 1;
        op(0, 1, 32'h40, 32'h0);
        idle(2);

        // Reset in the middle of a write drain
        ack_en = 0;
        for (int k = 0; k < 3; k++) op(1, 0, 32'h50 + 32'(k * 4), 32'h60 + 32'(k));
        idle(2);
        check("pre_rst_req", mem_req, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_rdata", cpu_rdata, 0);
        mem_ack = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        q.delete();
        prev_wr_ack = 0; rd_acked = 0; req_age = 0; last_rdata = '0;
        ack_en = 1;
        idle(5);
        ack_en = 0;
        for (int k = 0; k < 4; k++) op(1, 0, 32'h70 + 32'(k * 4), 32'h80 + 32'(k));
        cycle(1, 0, 32'h80, 32'h90, done);
        ack_en = 1; ack_lat = 0;
        drain();

        // Pointer wrap with intermittent acks
        rnd_ack = 1;
        for (int k = 0; k < 7; k++) op(1, 0, 32'h200 + 32'(k * 4), 32'h300 + 32'(k));
        drain();

        // Random traffic over a small address window to exercise aliasing
        for (int k = 0; k < 400; k++) begin
            r  = $urandom_range(0, 9);
            ra = 32'($urandom_range(0, 15)) << 2;
            if (r < 5)      op(1, 0, ra, $urandom());
            else if (r < 8) op(0, 1, ra, 32'h0);
            else if (r == 8) op(1, 1, ra, $urandom());
            else            idle(1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
